// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction-fetch queue.
//   fetch_slot_t        : one queue entry {pc, instr, filled}
//   FETCH_DEPTH_DEFAULT : default number of queue slots
//   PC_RESET            : architectural reset PC (informational)
package fetch_pkg;

  localparam int          FETCH_DEPTH_DEFAULT = 4;
  localparam logic [31:0] PC_RESET            = 32'h00400030;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        filled;
  } fetch_slot_t;

endpackage

// File: rtl/fetch_slot_array.sv
// fetch_slot_array: DEPTH-entry slot storage for the fetch queue.
// Ports:
//   clk, reset       clock / asynchronous active-high reset (filled flags only)
//   clear_all        drop every filled flag at the next edge (redirect)
//   alloc_en/idx/pc  allocate port: record request PC, mark slot unfilled
//   fill_en/idx/instr fill port: store returned instruction, mark filled
//   pop_en/idx       pop port: mark the head slot unfilled
//   head_idx         head read address
//   head_slot        head entry contents
// pc/instr storage carries no reset; it is only observed when filled=1.
import fetch_pkg::*;

module fetch_slot_array #(
  parameter  int DEPTH = FETCH_DEPTH_DEFAULT,
  localparam int IW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear_all,
  input  logic          alloc_en,
  input  logic [IW-1:0] alloc_idx,
  input  logic [31:0]   alloc_pc,
  input  logic          fill_en,
  input  logic [IW-1:0] fill_idx,
  input  logic [31:0]   fill_instr,
  input  logic          pop_en,
  input  logic [IW-1:0] pop_idx,
  input  logic [IW-1:0] head_idx,
  output fetch_slot_t   head_slot
);

  logic [31:0]      pc_q    [DEPTH];
  logic [31:0]      pc_d    [DEPTH];
  logic [31:0]      instr_q [DEPTH];
  logic [31:0]      instr_d [DEPTH];
  logic [DEPTH-1:0] filled_q;
  logic [DEPTH-1:0] filled_d;

  // Alloc, fill and pop never target the same slot in one cycle, so the
  // write order below only matters for the clear-all override.
  always_comb begin
    pc_d     = pc_q;
    instr_d  = instr_q;
    filled_d = filled_q;
    if (alloc_en) begin
      pc_d[alloc_idx]     = alloc_pc;
      filled_d[alloc_idx] = 1'b0;
    end
    if (fill_en) begin
      instr_d[fill_idx]  = fill_instr;
      filled_d[fill_idx] = 1'b1;
    end
    if (pop_en) begin
      filled_d[pop_idx] = 1'b0;
    end
    if (clear_all) begin
      filled_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    pc_q    <= pc_d;
    instr_q <= instr_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      filled_q <= '0;
    end else begin
      filled_q <= filled_d;
    end
  end

  assign head_slot = '{pc:     pc_q[head_idx],
                       instr:  instr_q[head_idx],
                       filled: filled_q[head_idx]};

endmodule

// File: rtl/fetch_queue.sv
// fetch_queue: instruction-fetch queue between the PC register and decode.
// Issues one imem read per cycle at currPC while a slot is free, tracks
// in-flight reads, buffers returned words in order with PC+4, and presents
// the head entry to decode. A decode redirect (FlushD) empties the queue and
// marks every in-flight read to be discarded on return.
// Ports:
//   clk, reset                  clock / asynchronous active-high reset
//   currPC -> imemAddr          fetch address passthrough
//   StallF                      hold PC register (low on accept or flush)
//   imemReq/imemGnt             request handshake
//   imemRvalid/imemRdata        in-order read responses
//   StallD, FlushD              decode hold / redirect
//   InstrD, PCPlus4D, ValidD    head entry (zeros when not valid)
// Optional build macro FETCH_PERF_EN adds fetchCount (pops) and dropCount
// (discarded responses) 32-bit wrapping counters.
import fetch_pkg::*;

module fetch_queue #(
  parameter int          DEPTH    = FETCH_DEPTH_DEFAULT,
  parameter logic [31:0] RESET_PC = PC_RESET
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] currPC,
  output logic        StallF,
  output logic        imemReq,
  output logic [31:0] imemAddr,
  input  logic        imemGnt,
  input  logic        imemRvalid,
  input  logic [31:0] imemRdata,
  input  logic        StallD,
  input  logic        FlushD,
  output logic [31:0] InstrD,
  output logic [31:0] PCPlus4D,
  output logic        ValidD
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] fetchCount,
  output logic [31:0] dropCount
`endif
);

  localparam int PW = $clog2(DEPTH) + 1;
  localparam int IW = PW - 1;
  // In-flight reads can exceed DEPTH when flushes stack up behind a slow
  // memory, so the counters get headroom beyond the pointer width.
  localparam int CW = PW + 4;
  localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);

  logic [PW-1:0] alloc_ptr_q, alloc_ptr_d;
  logic [PW-1:0] fill_ptr_q,  fill_ptr_d;
  logic [PW-1:0] read_ptr_q,  read_ptr_d;
  logic [CW-1:0] outstanding_q, outstanding_d;
  logic [CW-1:0] drop_cnt_q,    drop_cnt_d;

  logic [PW-1:0] count;
  logic          alloc;
  logic          rsp_take;
  logic          rsp_drop;
  logic          rsp_fill;
  logic          pop;
  logic          head_valid;
  fetch_slot_t   head;

  // RESET_PC is owned by the PC register; the wrap bit of fill_ptr is kept
  // only so all three pointers share one format.
  logic unused_ok;
  assign unused_ok = ^{RESET_PC, fill_ptr_q[PW-1]};

  assign count    = alloc_ptr_q - read_ptr_q;
  assign imemReq  = !reset && !FlushD && (count < DEPTH_P);
  assign imemAddr = currPC;
  assign alloc    = imemReq && imemGnt;
  assign StallF   = FlushD ? 1'b0 : !alloc;

  // Responses with nothing outstanding (e.g. strays after reset) are ignored.
  // While a flush is active the same-cycle response is already wrong-path.
  assign rsp_take = imemRvalid && (outstanding_q != '0);
  assign rsp_drop = rsp_take && (FlushD || (drop_cnt_q != '0));
  assign rsp_fill = rsp_take && !FlushD && (drop_cnt_q == '0);

  assign head_valid = head.filled && (count != '0);
  assign pop        = head_valid && !StallD && !FlushD;

  assign ValidD   = head_valid;
  assign InstrD   = head_valid ? head.instr : 32'd0;
  assign PCPlus4D = head_valid ? (head.pc + 32'd4) : 32'd0;

  fetch_slot_array #(.DEPTH(DEPTH)) u_slots (
    .clk        (clk),
    .reset      (reset),
    .clear_all  (FlushD),
    .alloc_en   (alloc),
    .alloc_idx  (alloc_ptr_q[IW-1:0]),
    .alloc_pc   (currPC),
    .fill_en    (rsp_fill),
    .fill_idx   (fill_ptr_q[IW-1:0]),
    .fill_instr (imemRdata),
    .pop_en     (pop),
    .pop_idx    (read_ptr_q[IW-1:0]),
    .head_idx   (read_ptr_q[IW-1:0]),
    .head_slot  (head)
  );

  always_comb begin
    alloc_ptr_d   = alloc_ptr_q;
    fill_ptr_d    = fill_ptr_q;
    read_ptr_d    = read_ptr_q;
    drop_cnt_d    = drop_cnt_q;
    outstanding_d = outstanding_q + CW'(alloc) - CW'(rsp_take);
    if (FlushD) begin
      alloc_ptr_d = '0;
      fill_ptr_d  = '0;
      read_ptr_d  = '0;
      // Every read still in flight after this cycle belongs to the old path.
      drop_cnt_d  = outstanding_q - CW'(rsp_take);
    end else begin
      if (alloc)    alloc_ptr_d = alloc_ptr_q + PW'(1);
      if (rsp_fill) fill_ptr_d  = fill_ptr_q + PW'(1);
      if (pop)      read_ptr_d  = read_ptr_q + PW'(1);
      if (rsp_drop) drop_cnt_d  = drop_cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      alloc_ptr_q   <= '0;
      fill_ptr_q    <= '0;
      read_ptr_q    <= '0;
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
    end else begin
      alloc_ptr_q   <= alloc_ptr_d;
      fill_ptr_q    <= fill_ptr_d;
      read_ptr_q    <= read_ptr_d;
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
    end
  end

`ifdef FETCH_PERF_EN
  logic [31:0] fetch_count_q, fetch_count_d;
  logic [31:0] drop_count_q,  drop_count_d;

  always_comb begin
    fetch_count_d = fetch_count_q + 32'(pop);
    drop_count_d  = drop_count_q + 32'(rsp_drop);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_count_q <= '0;
      drop_count_q  <= '0;
    end else begin
      fetch_count_q <= fetch_count_d;
      drop_count_q  <= drop_count_d;
    end
  end

  assign fetchCount = fetch_count_q;
  assign dropCount  = drop_count_q;
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: scoreboard bench for fetch_queue (DEPTH=4).
// A memory/PC model answers granted reads in order after `lat` cycles; every
// grant pushes the expected {instr, pc+4} into a queue that a negedge monitor
// pops when decode accepts. Directed checks cover reset, latency, stall,
// flush and reset-with-stray cases.
import fetch_pkg::*;

module tb_fetch_queue;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] currPC = PC_RESET;
  logic        StallF, imemReq, imemGnt = 1'b0;
  logic [31:0] imemAddr;
  logic        imemRvalid = 1'b0;
  logic [31:0] imemRdata = '0;
  logic        StallD = 1'b0, FlushD = 1'b0;
  logic [31:0] InstrD, PCPlus4D;
  logic        ValidD;
`ifdef FETCH_PERF_EN
  logic [31:0] fetchCount, dropCount;
`endif

  always #5 clk = ~clk;

  fetch_queue #(.DEPTH(DEPTH), .RESET_PC(PC_RESET)) dut (
    .clk        (clk),
    .reset      (reset),
    .currPC     (currPC),
    .StallF     (StallF),
    .imemReq    (imemReq),
    .imemAddr   (imemAddr),
    .imemGnt    (imemGnt),
    .imemRvalid (imemRvalid),
    .imemRdata  (imemRdata),
    .StallD     (StallD),
    .FlushD     (FlushD),
    .InstrD     (InstrD),
    .PCPlus4D   (PCPlus4D),
    .ValidD     (ValidD)
`ifdef FETCH_PERF_EN
    ,
    .fetchCount (fetchCount),
    .dropCount  (dropCount)
`endif
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  typedef struct { logic [31:0] addr; int due; } req_t;
  typedef struct { logic [31:0] instr; logic [31:0] pc4; } exp_t;
  req_t mem_q[$];
  exp_t exp_q[$];

  int          cyc = 0;
  int          lat = 1;
  logic        stray = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        stallf_s = 1'b1, flush_s = 1'b0, gnt_s = 1'b0;
  logic [31:0] addr_s = '0;

  // Memory + PC register model, updated just after each rising edge.
  always @(posedge clk) begin
    #1;
    if (reset) begin
      mem_q.delete();
      currPC     = PC_RESET;
      imemRvalid = 1'b0;
      imemRdata  = '0;
    end else begin
      if (gnt_s) mem_q.push_back('{addr: addr_s, due: cyc + lat});
      if (flush_s)        currPC = redirect_pc;
      else if (!stallf_s) currPC = currPC + 32'd4;
      imemRvalid = 1'b0;
      imemRdata  = '0;
      if (stray) begin
        imemRvalid = 1'b1;
        imemRdata  = 32'hDEADBEEF;
      end else if (mem_q.size() > 0 && mem_q[0].due <= cyc + 1) begin
        imemRvalid = 1'b1;
        imemRdata  = mem_word(mem_q[0].addr);
        void'(mem_q.pop_front());
      end
    end
    cyc++;
  end

  // Scoreboard monitor.
  always @(negedge clk) begin
    stallf_s = StallF;
    flush_s  = FlushD;
    gnt_s    = imemReq && imemGnt && !reset;
    addr_s   = imemAddr;
    if (reset) begin
      exp_q.delete();
    end else begin
      if (ValidD) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_valid: InstrD %h with no expected entry", InstrD);
        end else begin
          chk("sb_InstrD", InstrD, exp_q[0].instr);
          chk("sb_PCPlus4D", PCPlus4D, exp_q[0].pc4);
          if (!StallD && !FlushD) void'(exp_q.pop_front());
        end
      end else begin
        chk("idle_InstrD", InstrD, 32'd0);
        chk("idle_PCPlus4D", PCPlus4D, 32'd0);
      end
      if (FlushD) exp_q.delete();
      if (imemReq && imemGnt) exp_q.push_back('{instr: mem_word(imemAddr), pc4: imemAddr + 32'd4});
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #2;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) next_cycle();
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_StallF"}, 32'(StallF), 32'd1);
    chk({tag, "_imemReq"}, 32'(imemReq), 32'd0);
    chk({tag, "_ValidD"}, 32'(ValidD), 32'd0);
    chk({tag, "_InstrD"}, InstrD, 32'd0);
    chk({tag, "_PCPlus4D"}, PCPlus4D, 32'd0);
`ifdef FETCH_PERF_EN
    chk({tag, "_fetchCount"}, fetchCount, 32'd0);
    chk({tag, "_dropCount"}, dropCount, 32'd0);
`endif
  endtask

  initial begin
    int g0, v0, grants, pops;
    logic [31:0] pc_hold;

    // Reset state
    idle(2);
    @(negedge clk);
    chk_reset_state("rst");
    next_cycle();

    // Back-to-back fetch, latency 1
    reset = 1'b0;
    imemGnt = 1'b1;
    g0 = -1;
    v0 = -1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (g0 < 0 && imemReq && imemGnt) g0 = cyc;
      if (v0 >= 0) chk("stream_ValidD", 32'(ValidD), 32'd1);
      if (v0 < 0 && ValidD) begin
        v0 = cyc;
        chk("first_InstrD", InstrD, 32'h0030FFCF);
        chk("first_PCPlus4D", PCPlus4D, 32'h00400034);
      end
      next_cycle();
    end
    chk("grant_to_valid", 32'(v0 - g0), 32'd2);

    // Grant withheld 5 cycles: PC held, StallF high
    imemGnt = 1'b0;
    pc_hold = '0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i == 0) pc_hold = currPC;
      else chk("nogrant_currPC", currPC, pc_hold);
      chk("nogrant_StallF", 32'(StallF), 32'd1);
      next_cycle();
    end

    // Resume grants with decode stalled: exactly DEPTH allocations
    imemGnt = 1'b1;
    StallD  = 1'b1;
    grants  = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i == 0) begin
        chk("regrant_StallF", 32'(StallF), 32'd0);
        chk("regrant_addr", imemAddr, pc_hold);
      end
      if (imemReq && imemGnt) grants++;
      next_cycle();
    end
    @(negedge clk);
    chk("full_grants", 32'(grants), 32'd4);
    chk("full_imemReq", 32'(imemReq), 32'd0);
    chk("full_StallF", 32'(StallF), 32'd1);
    next_cycle();
    StallD = 1'b0;
    pops   = 0;
    grants = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (ValidD && !StallD) pops++;
      if (imemReq && imemGnt) grants++;
      next_cycle();
    end
    chk("release_pops", 32'(pops), 32'd4);
    chk("release_issue", 32'(grants != 0), 32'd1);

    // Flush with three reads in flight
    imemGnt = 1'b0;
    idle(6);
    lat = 4;
    redirect_pc = 32'h00400100;
    imemGnt = 1'b1;
    idle(3);
    FlushD = 1'b1;
    @(negedge clk);
    chk("flush_imemReq", 32'(imemReq), 32'd0);
    chk("flush_StallF", 32'(StallF), 32'd0);
    next_cycle();
    FlushD = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i == 0) chk("redirect_addr", imemAddr, 32'h00400100);
      chk("drop_ValidD", 32'(ValidD), 32'd0);
      next_cycle();
    end
    @(negedge clk);
    chk("newpath_ValidD", 32'(ValidD), 32'd1);
    chk("newpath_InstrD", InstrD, 32'h0100FEFF);
    chk("newpath_PCPlus4D", PCPlus4D, 32'h00400104);
`ifdef FETCH_PERF_EN
    chk("flush_dropCount", dropCount, 32'd3);
`endif
    next_cycle();
    idle(10);

    // Flush coinciding with a response while decode is stalled
    imemGnt = 1'b0;
    idle(8);
    lat = 1;
    StallD = 1'b1;
    imemGnt = 1'b1;
    @(negedge clk);
    chk("t4_grant", 32'(imemReq && imemGnt), 32'd1);
    next_cycle();
    imemGnt = 1'b0;
    FlushD = 1'b1;
    @(negedge clk);
    chk("t4_StallF", 32'(StallF), 32'd0);
    chk("t4_rvalid", 32'(imemRvalid), 32'd1);
    next_cycle();
    FlushD = 1'b0;
    @(negedge clk);
    chk("t4_ValidD", 32'(ValidD), 32'd0);
    chk("t4_empty_imemReq", 32'(imemReq), 32'd1);
`ifdef FETCH_PERF_EN
    chk("t4_dropCount", dropCount, 32'd4);
`endif
    next_cycle();
    @(negedge clk);
    chk("t4_ValidD_2", 32'(ValidD), 32'd0);
    next_cycle();
    StallD = 1'b0;

    // Reset with two reads in flight, then a stray response
    lat = 3;
    imemGnt = 1'b1;
    idle(2);
    imemGnt = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    chk_reset_state("midrst");
    idle(2);
    reset = 1'b0;
    idle(1);
    stray = 1'b1;
    next_cycle();
    stray = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i == 0) chk("stray_rvalid", 32'(imemRvalid), 32'd1);
      chk("stray_ValidD", 32'(ValidD), 32'd0);
      next_cycle();
    end
`ifdef FETCH_PERF_EN
    @(negedge clk);
    chk("stray_dropCount", dropCount, 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
